frame_sequencer: RTL

- Sequences one image-sensor frame through the phases erase, optional correlated-double-sampling reset read, exposure, ramp conversion and pixel readout.
- Drives the phase strobes, the `idle` flag and `pixel_select` consumed by the pixel array and its clock gate.
- Exposure length is programmable per frame; readout is paced by a downstream ready handshake.
- Supports single-shot and continuous capture.

---
 rtl/sensor_pkg.sv | 23 ++
 rtl/phase_timer.sv | 35 +++
 rtl/frame_sequencer.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/sensor_pkg.sv
// Shared types and default phase lengths for the image-sensor frame sequencer.
package sensor_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ERASE,
    ST_CORR,
    ST_EXPOSE,
    ST_CONVERT,
    ST_READ
  } seq_state_t;

  localparam int unsigned def_pixel_count    = 4;
  localparam int unsigned def_erase_cycles   = 4;
  localparam int unsigned def_corr_cycles    = 256;
  localparam int unsigned def_convert_cycles = 256;
  localparam int unsigned def_exp_width      = 16;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter with a registered zero flag; shared by every timed phase.
module phase_timer #(
  parameter int unsigned width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [width-1:0] load_value,
  output logic             zero
);

  logic [width-1:0] count_q;
  logic [width-1:0] count_d;

  // Saturates at zero so idle phases leave the counter parked.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_value;
    end else if (count_q != '0) begin
      count_d = count_q - width'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      zero    <= 1'b1;
    end else begin
      count_q <= count_d;
      zero    <= (count_d == '0);
    end
  end

endmodule

// File: rtl/frame_sequencer.sv
// Image-sensor frame sequencer: erase, optional CDS reset read, exposure, conversion, readout.
// Optional frame counter output enabled by defining FRAME_SEQ_FRAME_COUNT_EN.
module frame_sequencer
  import sensor_pkg::*;
#(
  parameter int unsigned pixel_count    = def_pixel_count,
  parameter int unsigned erase_cycles   = def_erase_cycles,
  parameter int unsigned corr_cycles    = def_corr_cycles,
  parameter int unsigned convert_cycles = def_convert_cycles,
  parameter int unsigned exp_width      = def_exp_width
) (
  input  logic                           system_clk,
  input  logic                           reset,
  input  logic                           enable,
  input  logic                           cont_mode,
  input  logic                           cds,
  input  logic [exp_width-1:0]           expose_time,
  input  logic                           read_ready,
  output logic                           erase,
  output logic                           corr,
  output logic                           expose,
  output logic                           convert,
  output logic                           read,
  output logic                           idle,
  output logic [$clog2(pixel_count)-1:0] pixel_select,
  output logic                           frame_done
`ifdef FRAME_SEQ_FRAME_COUNT_EN
  ,
  output logic [15:0]                    frame_count
`endif
);

  localparam int unsigned pix_w = $clog2(pixel_count);
  localparam int unsigned cnt_w = max_u(max_u(exp_width, $clog2(corr_cycles)),
                                        max_u($clog2(convert_cycles), $clog2(erase_cycles)));
  localparam logic [pix_w-1:0] pix_last  = pix_w'(pixel_count - 1);
  localparam logic [cnt_w-1:0] erase_v   = cnt_w'(erase_cycles - 1);
  localparam logic [cnt_w-1:0] corr_v    = cnt_w'(corr_cycles - 1);
  localparam logic [cnt_w-1:0] convert_v = cnt_w'(convert_cycles - 1);

  seq_state_t           state_q;
  seq_state_t           state_d;
  logic [pix_w-1:0]     pix_d;
  logic                 done_d;
  logic                 latch;
  logic                 cds_q;
  logic [exp_width-1:0] exp_q;
  logic                 tmr_load;
  logic [cnt_w-1:0]     tmr_value;
  logic                 tmr_zero;
  logic [cnt_w-1:0]     expose_v;

  assign expose_v = cnt_w'(exp_q - exp_width'(1));

  phase_timer #(.width(cnt_w)) u_timer (
    .clk        (system_clk),
    .rst        (reset),
    .load       (tmr_load),
    .load_value (tmr_value),
    .zero       (tmr_zero)
  );

  // Next-state, timer load and READ handshake.
  always_comb begin
    state_d   = state_q;
    pix_d     = pixel_select;
    done_d    = 1'b0;
    latch     = 1'b0;
    tmr_load  = 1'b0;
    tmr_value = '0;
    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d   = ST_ERASE;
          latch     = 1'b1;
          tmr_load  = 1'b1;
          tmr_value = erase_v;
        end
      end
      ST_ERASE: begin
        if (tmr_zero) begin
          tmr_load = 1'b1;
          if (cds_q) begin
            state_d   = ST_CORR;
            tmr_value = corr_v;
          end else begin
            state_d   = ST_EXPOSE;
            tmr_value = expose_v;
          end
        end
      end
      ST_CORR: begin
        if (tmr_zero) begin
          state_d   = ST_EXPOSE;
          tmr_load  = 1'b1;
          tmr_value = expose_v;
        end
      end
      ST_EXPOSE: begin
        if (tmr_zero) begin
          state_d   = ST_CONVERT;
          tmr_load  = 1'b1;
          tmr_value = convert_v;
        end
      end
      ST_CONVERT: begin
        if (tmr_zero) begin
          state_d = ST_READ;
          pix_d   = '0;
        end
      end
      ST_READ: begin
        if (read_ready) begin
          if (pixel_select == pix_last) begin
            done_d = 1'b1;
            pix_d  = '0;
            if (cont_mode) begin
              state_d   = ST_ERASE;
              latch     = 1'b1;
              tmr_load  = 1'b1;
              tmr_value = erase_v;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            pix_d = pixel_select + pix_w'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Per-frame settings; a zero exposure is stretched to one cycle.
  always_ff @(posedge system_clk or posedge reset) begin
    if (reset) begin
      cds_q <= 1'b0;
      exp_q <= '0;
    end else if (latch) begin
      cds_q <= cds;
      exp_q <= (expose_time == '0) ? exp_width'(1) : expose_time;
    end
  end

  // State register with phase strobes registered alongside it.
  always_ff @(posedge system_clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      idle         <= 1'b1;
      erase        <= 1'b0;
      corr         <= 1'b0;
      expose       <= 1'b0;
      convert      <= 1'b0;
      read         <= 1'b0;
      pixel_select <= '0;
      frame_done   <= 1'b0;
    end else begin
      state_q      <= state_d;
      idle         <= (state_d == ST_IDLE);
      erase        <= (state_d == ST_ERASE);
      corr         <= (state_d == ST_CORR);
      expose       <= (state_d == ST_EXPOSE);
      convert      <= (state_d == ST_CONVERT);
      read         <= (state_d == ST_READ);
      pixel_select <= pix_d;
      frame_done   <= done_d;
    end
  end

`ifdef FRAME_SEQ_FRAME_COUNT_EN
  always_ff @(posedge system_clk or posedge reset) begin
    if (reset) begin
      frame_count <= '0;
    end else if (done_d) begin
      frame_count <= frame_count + 16'd1;
    end
  end
`endif

endmodule
